axi_rd_arbiter: RTL
===================

// Module: axi_rd_arbiter
// PURPOSE
//  Merges the core's four AXI4 read-master ports (dbus, ibus, immu, dmmu) into one AXI4 read master toward the SoC crossbar.
//  Sits directly downstream of the core top wrapper; consumes its AR channels and returns R beats to the owning requester.
//  One transaction in flight at a time; round-robin grant; requester index prefixed onto ARID.
// PARAMETERS
//  NM   4   number of read requesters (0=dbus, 1=ibus, 2=immu, 3=dmmu)
//  IDW  5   per-requester ID width (narrower IDs zero-extended on entry)
//  AW   32  address width
//  DW   64  data width
// PORTS
//  clk_i       in   1         clock; everything on rising edge
//  arst_i      in   1         reset, asynchronous, active-low
//  s_arid      in   NM*IDW    requester ARID, slice k = requester k (same packing for all s_* ports)
//  s_araddr    in   NM*AW     requester ARADDR
//  s_arlen     in   NM*8      requester ARLEN
//  s_arsize    in   NM*3      requester ARSIZE
//  s_arburst   in   NM*2      requester ARBURST
//  s_arvalid   in   NM        requester ARVALID
//  s_arready   out  NM        requester ARREADY (one-hot or zero)
//  s_rid       out  IDW       RID, prefix stripped, broadcast to all requesters
//  s_rdata     out  DW        RDATA, broadcast
//  s_rresp     out  2         RRESP, broadcast
//  s_rlast     out  1         RLAST, broadcast
//  s_rvalid    out  NM        RVALID, only the owner's bit may be 1
//  s_rready    in   NM        requester RREADY
//  m_arid      out  IDW+2     {grant index[1:0], s_arid slice}
//  m_araddr/m_arlen/m_arsize/m_arburst  out  AW/8/3/2  registered AR fields
//  m_arvalid   out  1         ARVALID
//  m_arready   in   1         ARREADY
//  m_rid       in   IDW+2     RID
//  m_rdata     in   DW        RDATA
//  m_rresp     in   2         RRESP
//  m_rlast     in   1         RLAST
//  m_rvalid    in   1         RVALID
//  m_rready    out  1         RREADY
// BEHAVIOUR
//  Reset: state=IDLE, rr pointer=0, m_arvalid=0, m_rready=0, s_arready=0, s_rvalid=0, AR regs=0.
//  FSM IDLE -> ADDR -> DATA -> IDLE.
//  IDLE
//   - If any s_arvalid: grant g = first requester at/after the pointer (wrapping NM-1 -> 0).
//   - s_arready[g]=1 combinationally in that cycle; AR fields and g latched at the clock edge; -> ADDR.
//  ADDR
//   - m_arvalid=1 with latched fields; held stable until m_arready.
//   - On m_arvalid&m_arready -> DATA; no s_arready asserted in this state.
//  DATA
//   - m_rready = s_rready[g]; s_rvalid[g] = m_rvalid; all other s_rvalid=0.
//   - s_rid = m_rid[IDW-1:0]; routing uses latched g only; m_rid prefix is not checked.
//   - On m_rvalid&m_rready&m_rlast: -> IDLE, pointer = (g+1) mod NM.
//  Latency: s_ar accept at cycle T -> m_arvalid at T+1. rlast beat at T -> next s_arready at earliest T+1.
//  Beat count: arlen not counted; rlast alone ends the burst. rresp (incl. SLVERR/DECERR) passes through unmodified.
//  Simultaneous requests: exactly one grant; non-granted requesters keep arvalid and wait (AXI stability is their duty).
//  m_rvalid outside DATA: ignored, m_rready=0 (no beat consumed).
//  Reset mid-ADDR/DATA: FSM returns to IDLE immediately, in-flight transaction abandoned.
//  Pointer advances only on burst completion, never on grant.
// STRUCTURE
//  Shared package prv664_axi_pkg: AXI_BURST_FIXED/INCR/WRAP, AXI_RESP_* encodings,
//   RD_REQ_DBUS/IBUS/IMMU/DMMU index constants, AR-field struct typedef.
//  Sub-module rr_arbiter #(N): req[N], pointer in -> one-hot gnt[N] + index; purely combinational.
//  The pointer register lives in this block.
// TESTING
//  1. Single: dbus ar addr=0x8000_0000 len=3 id=5'h1A, slave 4 beats
//     -> m_arid=7'h1A (prefix 00), dbus gets 4 beats, rid=0x1A, rlast on beat 4.
//  2. All four arvalid together from reset -> grant order 0,1,2,3,
//     each m_arvalid only after the previous rlast.
//  3. After serving ibus(1), assert dbus+dmmu -> dmmu(3) granted before dbus(0) (wrap check).
//  4. s_rready[g] low 3 cycles mid-burst -> m_rready low, m_rdata beat held, no beat lost or duplicated.
//  5. m_arready low 10 cycles -> m_arvalid/m_araddr stable, all s_arready=0;
//     slave rresp=2'b10 on beat 2 -> passed unmodified.
//  6. arst_i low during DATA beat 2 of 4 -> outputs at reset values;
//     after release a new ibus request is granted cleanly with m_arid prefix 01.

Source files
------------

// File: rtl/prv664_axi_pkg.sv
// Shared AXI read-side definitions: burst/response encodings, read-requester
// index map, the AR control field bundle and the read arbiter state encoding.
package prv664_axi_pkg;

    // ARBURST encodings
    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    // RRESP / BRESP encodings
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // Read requester slots, in round-robin order
    localparam int RD_REQ_DBUS = 0;
    localparam int RD_REQ_IBUS = 1;
    localparam int RD_REQ_IMMU = 2;
    localparam int RD_REQ_DMMU = 3;
    localparam int RD_REQ_NUM  = 4;

    // Width of the requester index prefixed onto the downstream ARID
    localparam int RD_PFX_W = 2;

    // AR control fields latched together with the address
    typedef struct packed {
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
    } axi_ar_ctl_t;

    // Read arbiter state: one transaction in flight at a time
    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_ADDR = 2'd1,
        RD_DATA = 2'd2
    } rd_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first requester at or after the
// pointer position wins, wrapping from N-1 back to 0.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    // Scan N positions starting at the pointer; the first hit is latched via o_any
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!o_any && i_req[(int'(i_ptr) + i) % N]) begin
                o_gnt[(int'(i_ptr) + i) % N] = 1'b1;
                o_idx = IW'((int'(i_ptr) + i) % N);
                o_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Merges the core's read-master ports (dbus, ibus, immu, dmmu) into a single
// AXI4 read master. One burst in flight; round-robin grant; the requester
// index is prefixed onto ARID and R beats are routed back to the latched owner.
//
// Handshake semantics, all channels: a transfer happens on a rising clock
// edge where valid and ready are both high; valid never waits on ready, and
// the side asserting valid holds its payload stable until that edge.
module axi_rd_arbiter
    import prv664_axi_pkg::*;
#(
    parameter int NM  = RD_REQ_NUM,
    parameter int IDW = 5,
    parameter int AW  = 32,
    parameter int DW  = 64
) (
    input  logic                clk_i,
    input  logic                arst_i,

    // Requester-side AR channels, slice k belongs to requester k
    input  logic [NM*IDW-1:0]   s_arid,
    input  logic [NM*AW-1:0]    s_araddr,
    input  logic [NM*8-1:0]     s_arlen,
    input  logic [NM*3-1:0]     s_arsize,
    input  logic [NM*2-1:0]     s_arburst,
    input  logic [NM-1:0]       s_arvalid,
    output logic [NM-1:0]       s_arready,

    // Requester-side R channel: payload broadcast, valid per owner
    output logic [IDW-1:0]      s_rid,
    output logic [DW-1:0]       s_rdata,
    output logic [1:0]          s_rresp,
    output logic                s_rlast,
    output logic [NM-1:0]       s_rvalid,
    input  logic [NM-1:0]       s_rready,

    // Downstream AR channel
    output logic [IDW+1:0]      m_arid,
    output logic [AW-1:0]       m_araddr,
    output logic [7:0]          m_arlen,
    output logic [2:0]          m_arsize,
    output logic [1:0]          m_arburst,
    output logic                m_arvalid,
    input  logic                m_arready,

    // Downstream R channel
    input  logic [IDW+1:0]      m_rid,
    input  logic [DW-1:0]       m_rdata,
    input  logic [1:0]          m_rresp,
    input  logic                m_rlast,
    input  logic                m_rvalid,
    output logic                m_rready,

    // Current FSM state, for observation only
    output logic [1:0]          o_dbg_state
);

    localparam int GW = (NM > 1) ? $clog2(NM) : 1;

    rd_state_e        r_state;
    rd_state_e        w_state_nxt;
    logic [GW-1:0]    r_ptr;
    logic [GW-1:0]    r_gidx;
    logic [IDW-1:0]   r_id;
    logic [AW-1:0]    r_addr;
    axi_ar_ctl_t      r_ctl;

    logic [NM-1:0]    w_gnt;
    logic [GW-1:0]    w_gidx;
    logic             w_any;
    logic [IDW-1:0]   w_sel_id;
    logic [AW-1:0]    w_sel_addr;
    axi_ar_ctl_t      w_sel_ctl;
    logic             w_ar_take;
    logic             w_done;
    logic [GW-1:0]    w_ptr_nxt;
    logic             w_unused;

    // Requester-index bits of RID are not checked; routing uses the latched owner
    assign w_unused = &{1'b0, m_rid[IDW+1:IDW]};

    rr_arbiter #(
        .N  (NM),
        .IW (GW)
    ) u_rr (
        .i_req (s_arvalid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_gidx),
        .o_any (w_any)
    );

    // One-hot mux of the granted requester's AR fields
    always_comb begin
        w_sel_id   = '0;
        w_sel_addr = '0;
        w_sel_ctl  = '0;
        for (int k = 0; k < NM; k++) begin
            if (w_gnt[k]) begin
                w_sel_id   = s_arid[k*IDW +: IDW];
                w_sel_addr = s_araddr[k*AW +: AW];
                w_sel_ctl  = {s_arlen[k*8 +: 8], s_arsize[k*3 +: 3], s_arburst[k*2 +: 2]};
            end
        end
    end

    // Pointer moves to the requester after the one just served
    always_comb begin
        w_ptr_nxt = (r_gidx == GW'(NM - 1)) ? '0 : r_gidx + 1'b1;
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            r_state <= RD_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and handshake outputs; R routing only while owning a burst
    always_comb begin
        w_state_nxt = r_state;
        s_arready   = '0;
        m_arvalid   = 1'b0;
        m_rready    = 1'b0;
        s_rvalid    = '0;
        w_ar_take   = 1'b0;
        w_done      = 1'b0;
        unique case (r_state)
            RD_IDLE: begin
                if (w_any) begin
                    s_arready   = w_gnt;
                    w_ar_take   = 1'b1;
                    w_state_nxt = RD_ADDR;
                end
            end
            RD_ADDR: begin
                m_arvalid = 1'b1;
                if (m_arready) begin
                    w_state_nxt = RD_DATA;
                end
            end
            RD_DATA: begin
                m_rready         = s_rready[r_gidx];
                s_rvalid[r_gidx] = m_rvalid;
                if (m_rvalid && s_rready[r_gidx] && m_rlast) begin
                    w_done      = 1'b1;
                    w_state_nxt = RD_IDLE;
                end
            end
            default: begin
                w_state_nxt = RD_IDLE;
            end
        endcase
    end

    // Latch owner and AR fields on grant; advance the pointer on burst completion only
    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            r_ptr  <= '0;
            r_gidx <= '0;
            r_id   <= '0;
            r_addr <= '0;
            r_ctl  <= '0;
        end else begin
            if (w_ar_take) begin
                r_gidx <= w_gidx;
                r_id   <= w_sel_id;
                r_addr <= w_sel_addr;
                r_ctl  <= w_sel_ctl;
            end
            if (w_done) begin
                r_ptr <= w_ptr_nxt;
            end
        end
    end

    // Registered AR payload toward the crossbar
    always_comb begin
        m_arid      = {RD_PFX_W'(r_gidx), r_id};
        m_araddr    = r_addr;
        m_arlen     = r_ctl.len;
        m_arsize    = r_ctl.size;
        m_arburst   = r_ctl.burst;
        o_dbg_state = r_state;
    end

    // R payload is broadcast with the requester prefix stripped from RID
    always_comb begin
        s_rid   = m_rid[IDW-1:0];
        s_rdata = m_rdata;
        s_rresp = m_rresp;
        s_rlast = m_rlast;
    end

endmodule
